irq_ctrl: RTL and testbench

//   Memory-mapped interrupt controller that consumes per-peripheral level flags (e.g. the

---
 rtl/irq_ctrl.sv | 145 ++++++++++++++
 tb/tb_irq_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// Prioritised interrupt controller on the 8-bit IO bus: fixed priority (source 0 highest),
// registered request/vector, flag-clear pulses on acknowledge, no nesting until return.
module irq_ctrl #(
  parameter int unsigned N_SRC    = 8,
  parameter logic [7:0]  BASE     = 8'h10,
  parameter logic [7:0]  VEC_BASE = 8'h08
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       din,
  input  logic [7:0]       address,
  input  logic             w_en,
  input  logic             r_en,
  output logic [7:0]       dout,
  input  logic [N_SRC-1:0] irq_src,
  output logic [N_SRC-1:0] src_clr,
  output logic             irq_req,
  output logic [7:0]       irq_vector,
  input  logic             irq_ack,
  input  logic             irq_ret
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t           state, state_n;
  logic [N_SRC-1:0] ien, ien_n;
  logic             gie, gie_n;
  logic             in_service, in_service_n;
  logic [2:0]       isr_idx, isr_idx_n;
  logic [2:0]       idx, idx_n;
  logic             irq_req_n;
  logic [7:0]       irq_vector_n;
  logic [N_SRC-1:0] src_clr_n;
  logic [7:0]       dout_n;

  logic [N_SRC-1:0] pending;
  logic [2:0]       winner;
  logic             found;
  logic [7:0]       ien_rd, pend_rd;
  logic             wr_ien, wr_pend, wr_ctrl;

  assign pending = irq_src & ien;
  assign wr_ien  = w_en && (address == BASE);
  assign wr_pend = w_en && (address == BASE + 8'd1);
  assign wr_ctrl = w_en && (address == BASE + 8'd2);

  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (pending[i] && !found) begin
        winner = 3'(i);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_n      = state;
    ien_n        = wr_ien ? din[N_SRC-1:0] : ien;
    gie_n        = wr_ctrl ? din[0] : gie;
    in_service_n = in_service;
    isr_idx_n    = isr_idx;
    idx_n        = idx;
    irq_req_n    = irq_req;
    irq_vector_n = irq_vector;
    src_clr_n    = wr_pend ? din[N_SRC-1:0] : '0;

    // Hardware gie updates are assigned after the CTRL write so they take precedence.
    unique case (state)
      IDLE: begin
        irq_req_n = 1'b0;
        if (gie && |pending) begin
          idx_n        = winner;
          irq_vector_n = VEC_BASE + {3'b000, winner, 2'b00};
          irq_req_n    = 1'b1;
          state_n      = REQ;
        end
      end
      REQ: begin
        if (irq_ack) begin
          irq_req_n      = 1'b0;
          src_clr_n[idx] = 1'b1;
          gie_n          = 1'b0;
          in_service_n   = 1'b1;
          isr_idx_n      = idx;
          state_n        = SERVICE;
        end else if (!pending[idx] || !gie) begin
          irq_req_n = 1'b0;
          state_n   = IDLE;
        end
      end
      SERVICE: begin
        if (irq_ret) begin
          gie_n        = 1'b1;
          in_service_n = 1'b0;
          state_n      = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    ien_rd                = '0;
    ien_rd[N_SRC-1:0]     = ien;
    pend_rd               = '0;
    pend_rd[N_SRC-1:0]    = pending;
    dout_n                = dout;
    if (r_en) begin
      if (address == BASE)              dout_n = ien_rd;
      else if (address == BASE + 8'd1)  dout_n = pend_rd;
      else if (address == BASE + 8'd2)  dout_n = {6'b0, in_service, gie};
      else if (address == BASE + 8'd3)  dout_n = {in_service, 4'b0, isr_idx};
      else                              dout_n = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ien        <= '0;
      gie        <= 1'b0;
      in_service <= 1'b0;
      isr_idx    <= '0;
      idx        <= '0;
      irq_req    <= 1'b0;
      irq_vector <= '0;
      src_clr    <= '0;
      dout       <= '0;
    end else begin
      state      <= state_n;
      ien        <= ien_n;
      gie        <= gie_n;
      in_service <= in_service_n;
      isr_idx    <= isr_idx_n;
      idx        <= idx_n;
      irq_req    <= irq_req_n;
      irq_vector <= irq_vector_n;
      src_clr    <= src_clr_n;
      dout       <= dout_n;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: register vector table plus hand-written interrupt sequences;
// register reads are checked through a scoreboard queue when dout updates.
module tb_irq_ctrl;

  localparam logic [7:0] IEN  = 8'h10;
  localparam logic [7:0] PEND = 8'h11;
  localparam logic [7:0] CTRL = 8'h12;
  localparam logic [7:0] ISR  = 8'h13;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din = '0, address = '0;
  logic       w_en = 1'b0, r_en = 1'b0;
  logic [7:0] dout;
  logic [7:0] irq_src = '0;
  logic [7:0] src_clr;
  logic       irq_req;
  logic [7:0] irq_vector;
  logic       irq_ack = 1'b0, irq_ret = 1'b0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit         w;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } sb_t;

  vec_t tbl[$];
  sb_t  sbq[$];
  logic rd_d = 1'b0;

  irq_ctrl #(.N_SRC(8), .BASE(8'h10), .VEC_BASE(8'h08)) dut (
    .clk(clk), .rst(rst), .din(din), .address(address), .w_en(w_en), .r_en(r_en),
    .dout(dout), .irq_src(irq_src), .src_clr(src_clr), .irq_req(irq_req),
    .irq_vector(irq_vector), .irq_ack(irq_ack), .irq_ret(irq_ret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    address = a; din = d; w_en = 1'b1;
    step();
    w_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string name);
    address = a; r_en = 1'b1;
    sbq.push_back('{name, exp});
    step();
    r_en = 1'b0;
  endtask

  // dout is compared on the falling edge after the edge that registered the read
  always @(posedge clk) rd_d <= r_en;
  always @(negedge clk) begin
    if (rd_d) begin
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_underflow: got dout %h expected no read", dout);
      end else begin
        sb_t e;
        e = sbq.pop_front();
        chk(e.name, dout, e.exp);
      end
    end
  end

  initial begin
    rst = 1'b1;
    repeat (2) step();
    chk("rst_req", {7'b0, irq_req}, 8'h00);
    chk("rst_vec", irq_vector, 8'h00);
    chk("rst_clr", src_clr, 8'h00);
    chk("rst_dout", dout, 8'h00);
    rst = 1'b0;
    step();
    rd(CTRL, 8'h00, "rst_ctrl");
    rd(ISR,  8'h00, "rst_isr");

    // Register access table
    tbl.push_back('{1'b1, IEN,  8'hA5, 8'h00});
    tbl.push_back('{1'b0, IEN,  8'h00, 8'hA5});
    tbl.push_back('{1'b0, PEND, 8'h00, 8'h05});
    tbl.push_back('{1'b1, CTRL, 8'hFE, 8'h00});
    tbl.push_back('{1'b0, CTRL, 8'h00, 8'h00});
    tbl.push_back('{1'b0, ISR,  8'h00, 8'h00});
    tbl.push_back('{1'b1, IEN,  8'h00, 8'h00});
    tbl.push_back('{1'b0, PEND, 8'h00, 8'h00});
    tbl.push_back('{1'b1, CTRL, 8'h01, 8'h00});
    tbl.push_back('{1'b0, CTRL, 8'h00, 8'h01});
    tbl.push_back('{1'b1, CTRL, 8'h00, 8'h00});
    tbl.push_back('{1'b0, CTRL, 8'h00, 8'h00});
    irq_src = 8'h0F;
    foreach (tbl[i]) begin
      if (tbl[i].w) wr(tbl[i].addr, tbl[i].data);
      else          rd(tbl[i].addr, tbl[i].exp, $sformatf("tbl%0d", i));
    end
    irq_src = 8'h00;

    // Single source request, ack, clear pulse, return
    wr(IEN, 8'h01);
    wr(CTRL, 8'h01);
    irq_src = 8'h01;
    chk("t1_req_pre", {7'b0, irq_req}, 8'h00);
    step();
    chk("t1_req", {7'b0, irq_req}, 8'h01);
    chk("t1_vec", irq_vector, 8'h08);
    chk("t1_clr_pre", src_clr, 8'h00);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    chk("t1_req_ack", {7'b0, irq_req}, 8'h00);
    chk("t1_clr", src_clr, 8'h01);
    irq_src = 8'h00;
    step();
    chk("t1_clr_end", src_clr, 8'h00);
    rd(CTRL, 8'h02, "t1_ctrl");
    rd(ISR,  8'h80, "t1_isr");
    irq_ret = 1'b1; step(); irq_ret = 1'b0;
    rd(CTRL, 8'h01, "t1_ctrl_ret");

    // Ack while idle is ignored
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    chk("idle_ack_clr", src_clr, 8'h00);
    rd(CTRL, 8'h01, "idle_ack_ctrl");

    // Priority between two pending sources
    irq_src = 8'h0C;
    wr(IEN, 8'hFF);
    step();
    chk("t2_req", {7'b0, irq_req}, 8'h01);
    chk("t2_vec", irq_vector, 8'h10);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    chk("t2_clr", src_clr, 8'h04);
    irq_src = 8'h08;
    rd(ISR, 8'h82, "t2_isr");
    irq_ret = 1'b1; step(); irq_ret = 1'b0;
    chk("t2_req_ret", {7'b0, irq_req}, 8'h00);
    chk("t2_dout_hold", dout, 8'h82);
    step();
    chk("t2_req2", {7'b0, irq_req}, 8'h01);
    chk("t2_vec2", irq_vector, 8'h14);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    chk("t2_clr2", src_clr, 8'h08);
    irq_src = 8'h00;
    irq_ret = 1'b1; step(); irq_ret = 1'b0;
    step();

    // Withdrawal through PEND write-one-to-clear
    irq_src = 8'h02;
    step();
    chk("t3_req", {7'b0, irq_req}, 8'h01);
    chk("t3_vec", irq_vector, 8'h0C);
    wr(PEND, 8'h02);
    chk("t3_clr", src_clr, 8'h02);
    irq_src = 8'h00;
    step();
    chk("t3_req_drop", {7'b0, irq_req}, 8'h00);
    chk("t3_clr_end", src_clr, 8'h00);
    repeat (3) step();
    chk("t3_req_idle", {7'b0, irq_req}, 8'h00);
    rd(ISR, 8'h03, "t3_isr");

    // No nesting in service; CTRL write loses to ack clearing gie
    irq_src = 8'h08;
    step();
    chk("t4_req", {7'b0, irq_req}, 8'h01);
    irq_ack = 1'b1; address = CTRL; din = 8'h01; w_en = 1'b1;
    step();
    irq_ack = 1'b0; w_en = 1'b0;
    chk("t4_clr", src_clr, 8'h08);
    irq_src = 8'h01;
    rd(CTRL, 8'h02, "t4_ctrl_hw_wins");
    wr(CTRL, 8'h01);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t4_no_nest%0d", i), {7'b0, irq_req}, 8'h00);
    end
    rd(CTRL, 8'h03, "t4_ctrl");
    irq_ret = 1'b1; step(); irq_ret = 1'b0;
    chk("t4_req_ret", {7'b0, irq_req}, 8'h00);
    step();
    chk("t4_req_after", {7'b0, irq_req}, 8'h01);
    chk("t4_vec", irq_vector, 8'h08);

    // Asynchronous reset while requesting
    #2 rst = 1'b1;
    #1;
    chk("t6_req_async", {7'b0, irq_req}, 8'h00);
    chk("t6_clr_async", src_clr, 8'h00);
    chk("t6_vec_async", irq_vector, 8'h00);
    step(); step();
    rst = 1'b0;
    step();
    chk("t6_req", {7'b0, irq_req}, 8'h00);
    chk("t6_clr", src_clr, 8'h00);
    rd(IEN,  8'h00, "t6_ien");
    rd(CTRL, 8'h00, "t6_ctrl");

    // Return outside service is ignored
    irq_ret = 1'b1; step(); irq_ret = 1'b0;
    rd(CTRL, 8'h00, "ret_idle_ctrl");

    #10;
    chk("sb_empty", 8'(sbq.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
